// File: rtl/y86_pkg.sv
// y86_pkg: status codes, sequencer state encoding and stage-enable bit positions
// shared by the Y86-64 SEQ sequencer and its bench.
package y86_pkg;
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;
    localparam int STG_FETCH = 0;
    localparam int STG_DEC   = 1;
    localparam int STG_EXE   = 2;
    localparam int STG_MEM   = 3;
    localparam int STG_WB    = 4;
    localparam int STG_PCUPD = 5;
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_PAUSE, S_HALTED
    } seq_state_t;
    function automatic logic [5:0] stage_onehot(seq_state_t s);
        return s == S_FETCH     ? 6'b1 << STG_FETCH :
               s == S_DECODE    ? 6'b1 << STG_DEC   :
               s == S_EXECUTE   ? 6'b1 << STG_EXE   :
               s == S_MEMORY    ? 6'b1 << STG_MEM   :
               s == S_WRITEBACK ? 6'b1 << STG_WB    :
               s == S_PCUPD     ? 6'b1 << STG_PCUPD : 6'b0;
    endfunction
endpackage

// File: rtl/y86_sat_counter.sv
// y86_sat_counter: up-counter with synchronous clear that sticks at all-ones.
module y86_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;
    always_ff @(posedge clk)
        r_q <= rst || i_clr ? '0 : i_inc && !(&r_q) ? r_q + 1'b1 : r_q;
    assign o_q = r_q;
endmodule

// File: rtl/y86_seq_sequencer.sv
// y86_seq_sequencer: multi-cycle stage sequencer owning PC and Y86 status.
// Define SEQ_PERF_EN to add mem_stall_cnt and last_fault_pc.
module y86_seq_sequencer
    import y86_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int CNT_W = 32,
    parameter int MEM_TIMEOUT = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step_mode,
    input  logic              step,
    input  logic              hlt,
    input  logic              inst_invalid,
    input  logic              mem_ready,
    input  logic              mem_error,
    input  logic [ADDR_W-1:0] pc_next,
    output logic [5:0]        stage_en,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        stat,
    output logic              running,
    output logic              paused,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instr_cnt
`ifdef SEQ_PERF_EN
    ,
    output logic [CNT_W-1:0]  mem_stall_cnt,
    output logic [ADDR_W-1:0] last_fault_pc
`endif
);
    localparam int WAIT_W = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    seq_state_t        r_state, w_next;
    logic [WAIT_W-1:0] r_wait;
    logic [ADDR_W-1:0] r_pc;
    logic [2:0]        r_stat;
    logic [5:0]        r_stage_en;
    logic              w_start, w_mem_fault, w_retire;

    assign w_start     = start && (r_state == S_IDLE || r_state == S_HALTED);
    assign w_mem_fault = r_state == S_MEMORY && (mem_error || (!mem_ready && r_wait == WAIT_LAST));
    assign w_retire    = r_state == S_PCUPD || (r_state == S_FETCH && hlt && !inst_invalid);

    always_ff @(posedge clk)
        r_state <= rst ? S_IDLE : w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_HALTED: w_next = start ? S_FETCH : r_state;
            S_FETCH:          w_next = inst_invalid || hlt ? S_HALTED : S_DECODE;
            S_DECODE:         w_next = S_EXECUTE;
            S_EXECUTE:        w_next = S_MEMORY;
            S_MEMORY:         w_next = w_mem_fault ? S_HALTED : mem_ready ? S_WRITEBACK : S_MEMORY;
            S_WRITEBACK:      w_next = S_PCUPD;
            S_PCUPD:          w_next = step_mode ? S_PAUSE : S_FETCH;
            S_PAUSE:          w_next = step || !step_mode ? S_FETCH : S_PAUSE;
            default:          w_next = S_IDLE;
        endcase
    end

    // stage_en is registered from the next state so it lines up with r_state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_stat     <= STAT_AOK;
            r_wait     <= '0;
            r_stage_en <= '0;
        end else begin
            r_stage_en <= stage_onehot(w_next);
            r_wait     <= r_state == S_MEMORY ? r_wait + 1'b1 : '0;
            if (w_start)
                r_pc <= RESET_PC;
            else if (r_state == S_PCUPD)
                r_pc <= pc_next;
            if (w_start)
                r_stat <= STAT_AOK;
            else if (r_state == S_FETCH && inst_invalid)
                r_stat <= STAT_INS;
            else if (r_state == S_FETCH && hlt)
                r_stat <= STAT_HLT;
            else if (w_mem_fault)
                r_stat <= STAT_ADR;
        end
    end

    always_comb begin
        stage_en = r_stage_en;
        running  = |r_stage_en;
        paused   = r_state == S_PAUSE;
        pc       = r_pc;
        stat     = r_stat;
    end

    y86_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk(clk), .rst(rst), .i_clr(w_start), .i_inc(running || paused), .o_q(cycle_cnt)
    );
    y86_sat_counter #(.W(CNT_W)) u_instr_cnt (
        .clk(clk), .rst(rst), .i_clr(w_start), .i_inc(w_retire), .o_q(instr_cnt)
    );

`ifdef SEQ_PERF_EN
    logic [ADDR_W-1:0] r_fault_pc;
    logic              w_fault;
    assign w_fault = w_mem_fault || (r_state == S_FETCH && inst_invalid);
    y86_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk(clk), .rst(rst), .i_clr(w_start), .i_inc(r_state == S_MEMORY && !mem_ready), .o_q(mem_stall_cnt)
    );
    always_ff @(posedge clk)
        r_fault_pc <= rst ? RESET_PC : w_fault ? r_pc : r_fault_pc;
    assign last_fault_pc = r_fault_pc;
`endif
endmodule

// File: tb/tb_y86_seq_sequencer.sv
// tb_y86_seq_sequencer: randomized scenario bench for the SEQ sequencer, checked
// against a cycle/instruction/PC reference model kept by the bench.
module tb_y86_seq_sequencer;
    import y86_pkg::*;
    localparam logic [5:0] E_F = 6'b000001, E_D = 6'b000010, E_E = 6'b000100;
    localparam logic [5:0] E_M = 6'b001000, E_W = 6'b010000, E_P = 6'b100000;

    logic clk = 1'b0;
    logic rst = 1'b0, start = 1'b0, step_mode = 1'b0, step = 1'b0, hlt = 1'b0;
    logic inst_invalid = 1'b0, mem_ready = 1'b0, mem_error = 1'b0;
    logic [63:0] pc_next = '0, pc;
    logic [5:0] stage_en;
    logic [2:0] stat;
    logic running, paused;
    logic [31:0] cycle_cnt, instr_cnt;
`ifdef SEQ_PERF_EN
    logic [31:0] mem_stall_cnt;
    logic [63:0] last_fault_pc;
`endif
    int n_tot = 0, n_pass = 0;
    logic [63:0] m_pc;
    int m_instr = 0, m_cyc = 0;

    always #5 clk = ~clk;

    y86_seq_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step(step), .hlt(hlt),
        .inst_invalid(inst_invalid), .mem_ready(mem_ready), .mem_error(mem_error), .pc_next(pc_next),
        .stage_en(stage_en), .pc(pc), .stat(stat), .running(running), .paused(paused),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`ifdef SEQ_PERF_EN
        , .mem_stall_cnt(mem_stall_cnt), .last_fault_pc(last_fault_pc)
`endif
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
        m_pc = '0;
        m_instr = 0;
        m_cyc = 0;
    endtask

    // follows one instruction from FETCH through PCUPD, answering memory after lat cycles
    task automatic run_instr(input int lat, input logic [63:0] nxt, output int cyc);
        int k;
        bit done;
        k = 0;
        cyc = 0;
        done = 0;
        pc_next = nxt;
        while (cyc < 64 && !done) begin
            mem_ready = stage_en[STG_MEM] && (k == lat - 1);
            if (stage_en[STG_MEM]) k++;
            done = stage_en[STG_PCUPD];
            cyc++;
            tick();
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_tot++; if (stage_en !== 6'b0) $display("FAIL reset_stage_en got %b exp 0", stage_en); else n_pass++;
        n_tot++; if (pc !== 64'd0) $display("FAIL reset_pc got %0h exp 0", pc); else n_pass++;
        n_tot++; if (stat !== 3'd1) $display("FAIL reset_stat got %0d exp 1", stat); else n_pass++;
        n_tot++; if (running !== 1'b0 || paused !== 1'b0) $display("FAIL reset_flags got %b%b exp 00", running, paused); else n_pass++;
        n_tot++; if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) $display("FAIL reset_cnt got %0d/%0d exp 0/0", cycle_cnt, instr_cnt); else n_pass++;
        repeat (3) tick();
        n_tot++; if (stage_en !== 6'b0 || cycle_cnt !== 32'd0) $display("FAIL idle_hold got %b/%0d exp 0/0", stage_en, cycle_cnt); else n_pass++;
    endtask

    task automatic test_basic;
        logic [5:0] seq [6];
        int cyc;
        seq = '{E_F, E_D, E_E, E_M, E_W, E_P};
        do_start();
        n_tot++; if (stage_en !== E_F || cycle_cnt !== 32'd0) $display("FAIL start_fetch got %b/%0d exp %b/0", stage_en, cycle_cnt, E_F); else n_pass++;
        mem_ready = 1'b1;
        pc_next = 64'd10;
        for (int i = 0; i < 6; i++) begin
            n_tot++; if (stage_en !== seq[i] || running !== 1'b1) $display("FAIL stage_seq%0d got %b/%b exp %b/1", i, stage_en, running, seq[i]); else n_pass++;
            tick();
        end
        mem_ready = 1'b0;
        m_pc = 64'd10; m_instr = 1; m_cyc = 6;
        for (int i = 0; i < 2; i++) begin
            run_instr(1, m_pc + 64'd10, cyc);
            m_pc += 64'd10; m_instr++; m_cyc += 6;
            n_tot++; if (cyc !== 6) $display("FAIL basic_latency got %0d exp 6", cyc); else n_pass++;
        end
        hlt = 1'b1;
        tick();
        hlt = 1'b0;
        m_instr++; m_cyc++;
        n_tot++; if (pc !== 64'd30) $display("FAIL hlt_pc got %0d exp 30", pc); else n_pass++;
        n_tot++; if (stat !== STAT_HLT) $display("FAIL hlt_stat got %0d exp 2", stat); else n_pass++;
        n_tot++; if (instr_cnt !== 32'd4 || instr_cnt !== 32'(m_instr)) $display("FAIL hlt_instr got %0d exp 4", instr_cnt); else n_pass++;
        n_tot++; if (cycle_cnt !== 32'd19 || cycle_cnt !== 32'(m_cyc)) $display("FAIL hlt_cycles got %0d exp 19", cycle_cnt); else n_pass++;
        n_tot++; if (stage_en !== 6'b0 || running !== 1'b0) $display("FAIL hlt_idle got %b/%b exp 0/0", stage_en, running); else n_pass++;
        step = 1'b1; step_mode = 1'b1; mem_ready = 1'b1; hlt = 1'b1; inst_invalid = 1'b1;
        repeat (3) tick();
        step = 1'b0; step_mode = 1'b0; mem_ready = 1'b0; hlt = 1'b0; inst_invalid = 1'b0;
        n_tot++; if (stat !== STAT_HLT || cycle_cnt !== 32'd19 || pc !== 64'd30) $display("FAIL halted_hold got %0d/%0d/%0d exp 2/19/30", stat, cycle_cnt, pc); else n_pass++;
    endtask

    task automatic test_random;
        int lat, cyc;
        logic [63:0] nxt;
        do_start();
        n_tot++; if (stat !== STAT_AOK || pc !== 64'd0 || stage_en !== E_F) $display("FAIL restart_hlt got %0d/%0h/%b exp 1/0/%b", stat, pc, stage_en, E_F); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            lat = i == 0 ? 3 : int'($urandom_range(1, 6));
            nxt = {$urandom, $urandom};
            run_instr(lat, nxt, cyc);
            m_pc = nxt; m_instr++; m_cyc += 5 + lat;
            n_tot++; if (cyc !== 5 + lat) $display("FAIL rand_latency%0d got %0d exp %0d", i, cyc, 5 + lat); else n_pass++;
            n_tot++; if (pc !== m_pc) $display("FAIL rand_pc%0d got %0h exp %0h", i, pc, m_pc); else n_pass++;
        end
        n_tot++; if (instr_cnt !== 32'(m_instr) || cycle_cnt !== 32'(m_cyc)) $display("FAIL rand_cnt got %0d/%0d exp %0d/%0d", instr_cnt, cycle_cnt, m_instr, m_cyc); else n_pass++;
    endtask

    task automatic test_timeout;
        int cnt;
        repeat (3) tick();
        cnt = 0;
        while (stage_en[STG_MEM] && cnt < 40) begin
            cnt++;
            tick();
        end
        m_cyc += 3 + cnt;
        n_tot++; if (cnt !== 16) $display("FAIL timeout_cycles got %0d exp 16", cnt); else n_pass++;
        n_tot++; if (stat !== STAT_ADR || stage_en !== 6'b0) $display("FAIL timeout_stat got %0d/%b exp 3/0", stat, stage_en); else n_pass++;
        n_tot++; if (pc !== m_pc || instr_cnt !== 32'(m_instr)) $display("FAIL timeout_pc got %0h/%0d exp %0h/%0d", pc, instr_cnt, m_pc, m_instr); else n_pass++;
        n_tot++; if (cycle_cnt !== 32'(m_cyc)) $display("FAIL timeout_cnt got %0d exp %0d", cycle_cnt, m_cyc); else n_pass++;
        do_start();
        n_tot++; if (stat !== STAT_AOK || pc !== 64'd0 || stage_en !== E_F || cycle_cnt !== 32'd0) $display("FAIL restart_adr got %0d/%0h/%b/%0d exp 1/0/%b/0", stat, pc, stage_en, cycle_cnt, E_F); else n_pass++;
        repeat (3) tick();
        mem_ready = 1'b1; mem_error = 1'b1;
        tick();
        mem_ready = 1'b0; mem_error = 1'b0;
        n_tot++; if (stat !== STAT_ADR || stage_en !== 6'b0 || pc !== 64'd0) $display("FAIL err_wins got %0d/%b/%0h exp 3/0/0", stat, stage_en, pc); else n_pass++;
    endtask

    task automatic test_invalid;
        int cyc;
        do_start();
        run_instr(1, {$urandom, $urandom}, cyc);
        m_pc = pc_next; m_instr++;
        inst_invalid = 1'b1; hlt = 1'b1;
        tick();
        inst_invalid = 1'b0; hlt = 1'b0;
        n_tot++; if (stat !== STAT_INS || stage_en !== 6'b0) $display("FAIL ins_stat got %0d/%b exp 4/0", stat, stage_en); else n_pass++;
        n_tot++; if (instr_cnt !== 32'(m_instr) || pc !== m_pc) $display("FAIL ins_keep got %0d/%0h exp %0d/%0h", instr_cnt, pc, m_instr, m_pc); else n_pass++;
    endtask

    task automatic test_step;
        int cyc;
        logic [63:0] nxt;
        do_start();
        step_mode = 1'b1;
        run_instr(2, 64'h100, cyc);
        m_pc = 64'h100; m_instr++; m_cyc += 7;
        n_tot++; if (paused !== 1'b1 || running !== 1'b0 || stage_en !== 6'b0) $display("FAIL pause_enter got %b/%b/%b exp 1/0/0", paused, running, stage_en); else n_pass++;
        n_tot++; if (instr_cnt !== 32'(m_instr)) $display("FAIL pause_instr got %0d exp %0d", instr_cnt, m_instr); else n_pass++;
        start = 1'b1;
        repeat (4) tick();
        start = 1'b0;
        m_cyc += 4;
        n_tot++; if (paused !== 1'b1 || cycle_cnt !== 32'(m_cyc)) $display("FAIL pause_hold got %b/%0d exp 1/%0d", paused, cycle_cnt, m_cyc); else n_pass++;
        step = 1'b1;
        tick();
        step = 1'b0;
        m_cyc++;
        n_tot++; if (stage_en !== E_F || paused !== 1'b0) $display("FAIL step_fetch got %b/%b exp %b/0", stage_en, paused, E_F); else n_pass++;
        tick();
        tick();
        n_tot++; if (stage_en !== E_E) $display("FAIL step_exe got %b exp %b", stage_en, E_E); else n_pass++;
        step = 1'b1;
        tick();
        step = 1'b0;
        n_tot++; if (stage_en !== E_M) $display("FAIL step_ignored got %b exp %b", stage_en, E_M); else n_pass++;
        nxt = {$urandom, $urandom} | 64'd1;
        pc_next = nxt;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        n_tot++; if (stage_en !== E_P) $display("FAIL step_pcupd got %b exp %b", stage_en, E_P); else n_pass++;
        tick();
        m_pc = nxt; m_instr++; m_cyc += 6;
        n_tot++; if (paused !== 1'b1 || instr_cnt !== 32'(m_instr) || pc !== m_pc) $display("FAIL step_second got %b/%0d/%0h exp 1/%0d/%0h", paused, instr_cnt, pc, m_instr, m_pc); else n_pass++;
        step_mode = 1'b0;
        tick();
        m_cyc++;
        n_tot++; if (stage_en !== E_F || cycle_cnt !== 32'(m_cyc)) $display("FAIL step_drop got %b/%0d exp %b/%0d", stage_en, cycle_cnt, E_F, m_cyc); else n_pass++;
    endtask

    task automatic test_reset_mid;
        tick();
        tick();
        n_tot++; if (stage_en !== E_E) $display("FAIL mid_exe got %b exp %b", stage_en, E_E); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tot++; if (stage_en !== 6'b0 || running !== 1'b0 || pc !== 64'd0 || stat !== STAT_AOK) $display("FAIL mid_rst got %b/%b/%0h/%0d exp 0/0/0/1", stage_en, running, pc, stat); else n_pass++;
        n_tot++; if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) $display("FAIL mid_rst_cnt got %0d/%0d exp 0/0", cycle_cnt, instr_cnt); else n_pass++;
    endtask

`ifdef SEQ_PERF_EN
    task automatic test_perf;
        int cyc;
        n_tot++; if (last_fault_pc !== 64'd0) $display("FAIL perf_reset got %0h exp 0", last_fault_pc); else n_pass++;
        do_start();
        run_instr(3, 64'h20, cyc);
        run_instr(6, 64'h40, cyc);
        n_tot++; if (mem_stall_cnt !== 32'd7) $display("FAIL perf_stall got %0d exp 7", mem_stall_cnt); else n_pass++;
        repeat (3) tick();
        mem_error = 1'b1;
        tick();
        mem_error = 1'b0;
        n_tot++; if (stat !== STAT_ADR || last_fault_pc !== 64'h40) $display("FAIL perf_fault_pc got %0d/%0h exp 3/40", stat, last_fault_pc); else n_pass++;
    endtask
`endif

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog expired after 50000 cycles");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_random();
        test_timeout();
        test_invalid();
        test_step();
        test_reset_mid();
`ifdef SEQ_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
